// File: rtl/rol_pipe_pkg.sv
// Shared constants and stage record for the pipelined rotate-left unit.
package rol_pipe_pkg;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned SHW   = $clog2(WIDTH);
    localparam int unsigned TAG_W = 4;

    // Contents of one pipeline stage: valid bit, partially rotated data,
    // the full shift amount (each stage consumes one bit) and the sideband tag.
    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
        logic [SHW-1:0]   shamt;
        logic [TAG_W-1:0] tag;
    } rol_stage_t;

endpackage

// File: rtl/rol_pipe_if.sv
// Operand/result handshake bundle for the rotate-left unit.
interface rol_pipe_if;
    import rol_pipe_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_shift;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [TAG_W-1:0] out_tag;

    // Producer/consumer side (drives operands, accepts results).
    modport master (
        output in_valid, in_data, in_shift, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    // Rotate unit side.
    modport slave (
        input  in_valid, in_data, in_shift, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );

endinterface

// File: rtl/rol_stage.sv
// One registered conditional-rotate stage: rotates left by Dist when shift bit
// ShBit is set, otherwise passes data through. Holds while adv_i is low.
module rol_stage
    import rol_pipe_pkg::*;
#(
    parameter int unsigned Dist  = 1,
    parameter int unsigned ShBit = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       adv_i,
    input  rol_stage_t stage_i,
    output rol_stage_t stage_o
);

    rol_stage_t stage_d, stage_q;

    // Conditional rotate of the incoming record; everything else passes through.
    always_comb begin
        stage_d = stage_i;
        if (stage_i.shamt[ShBit]) begin
            stage_d.data = {stage_i.data[WIDTH-1-Dist:0], stage_i.data[WIDTH-1:WIDTH-Dist]};
        end
    end

    // Stage register; bubbles advance exactly like valid entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= '0;
        end else if (adv_i) begin
            stage_q <= stage_d;
        end
    end

    assign stage_o = stage_q;

endmodule

// File: rtl/rol_pipe.sv
// Pipelined rotate-left unit: one register stage per shift-amount bit, largest
// rotation first, followed by an output register. Whole pipe stalls together.
module rol_pipe
    import rol_pipe_pkg::*;
(
    input logic       clk,
    input logic       rst,
    rol_pipe_if.slave bus
);

    rol_stage_t [SHW:0] st;
    logic               advance;

    logic               out_valid_q;
    logic [WIDTH-1:0]   out_data_q;
    logic [TAG_W-1:0]   out_tag_q;

    // Only the output register can block; everything moves when it is empty or drained.
    assign advance      = !out_valid_q || bus.out_ready;
    assign bus.in_ready = advance;

    // Stage 0 input is the operand itself; valid only on an actual transfer.
    assign st[0] = '{
        valid: bus.in_valid && advance,
        data:  bus.in_data,
        shamt: bus.in_shift,
        tag:   bus.in_tag
    };

    for (genvar s = 0; s < SHW; s++) begin : g_stage
        rol_stage #(
            .Dist  (1 << (SHW - 1 - s)),
            .ShBit (SHW - 1 - s)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .adv_i   (advance),
            .stage_i (st[s]),
            .stage_o (st[s+1])
        );
    end

    // Shift amount is fully consumed by the last stage.
    logic unused_shamt;
    assign unused_shamt = ^st[SHW].shamt;

    // Output register; holds its result while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
        end else if (advance) begin
            out_valid_q <= st[SHW].valid;
            out_data_q  <= st[SHW].data;
            out_tag_q   <= st[SHW].tag;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_tag   = out_tag_q;

endmodule

// File: tb/tb_rol_pipe.sv
// Directed and randomised checks for rol_pipe.
module tb_rol_pipe;
    import rol_pipe_pkg::*;

    logic clk;
    logic rst;

    rol_pipe_if ifc ();

    rol_pipe u_dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int unsigned n_pass  = 0;
    int unsigned n_fail  = 0;
    int unsigned n_total = 0;
    int unsigned n_acc   = 0;

    logic [19:0] exp_q[$];
    logic [19:0] got_q[$];

    function automatic logic [15:0] rol_ref(logic [15:0] d, logic [3:0] s);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[(i + int'(s)) % 16] = d[i];
        return r;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge with inputs set; records transfers, then
    // advances one full clock.
    task automatic tick();
        logic [19:0] e;
        #1;
        if (ifc.in_valid && ifc.in_ready) begin
            exp_q.push_back({rol_ref(ifc.in_data, ifc.in_shift), ifc.in_tag});
            n_acc++;
        end
        if (ifc.out_valid && ifc.out_ready) begin
            got_q.push_back({ifc.out_data, ifc.out_tag});
            chk("sb_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_data", 32'(ifc.out_data), 32'(e[19:4]));
                chk("sb_tag", 32'(ifc.out_tag), 32'(e[3:0]));
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(logic [15:0] d, logic [3:0] s, logic [3:0] t);
        ifc.in_valid = 1'b1;
        ifc.in_data  = d;
        ifc.in_shift = s;
        ifc.in_tag   = t;
        tick();
        ifc.in_valid = 1'b0;
    endtask

    task automatic drain(int unsigned n);
        int unsigned guard;
        guard = 0;
        while (got_q.size() < n && guard < 60) begin
            tick();
            guard++;
        end
        chk("drain_count", 32'(got_q.size()), 32'(n));
    endtask

    initial begin
        int unsigned lat;
        int unsigned nv;
        int unsigned guard;
        int unsigned acc0;
        logic [15:0] hold_d;
        logic [3:0]  hold_t;
        logic [15:0] s_data[4];
        logic [3:0]  s_sh[4];
        logic [15:0] s_exp[4];

        ifc.in_valid  = 1'b0;
        ifc.in_data   = '0;
        ifc.in_shift  = '0;
        ifc.in_tag    = '0;
        ifc.out_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(ifc.out_valid), 32'd0);
        chk("rst_out_data", 32'(ifc.out_data), 32'd0);
        chk("rst_out_tag", 32'(ifc.out_tag), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 32'(ifc.in_ready), 32'd1);
        @(negedge clk);

        // Single operand: latency and value.
        ifc.out_ready = 1'b1;
        send(16'h8001, 4'd1, 4'd3);
        lat = 0;
        while (!ifc.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("single_latency", 32'(lat), 32'd4);
        chk("single_data", 32'(ifc.out_data), 32'h0003);
        chk("single_tag", 32'(ifc.out_tag), 32'd3);
        tick();
        nv = 0;
        for (int i = 0; i < 6; i++) begin
            nv += 32'(ifc.out_valid);
            tick();
        end
        chk("single_no_extra", 32'(nv), 32'd0);

        // Streamed operands, one per cycle.
        got_q.delete();
        s_data = '{16'h1234, 16'h1234, 16'hABCD, 16'hABCD};
        s_sh   = '{4'd4, 4'd8, 4'd0, 4'd15};
        s_exp  = '{16'h2341, 16'h3412, 16'hABCD, 16'hD5E6};
        for (int i = 0; i < 4; i++) begin
            ifc.in_valid = 1'b1;
            ifc.in_data  = s_data[i];
            ifc.in_shift = s_sh[i];
            ifc.in_tag   = 4'(i + 5);
            tick();
        end
        ifc.in_valid = 1'b0;
        drain(4);
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            chk("stream_data", 32'(got_q[i][19:4]), 32'(s_exp[i]));
            chk("stream_tag", 32'(got_q[i][3:0]), 32'(i + 5));
        end

        // Backpressure: stall with result at the output.
        got_q.delete();
        s_data = '{16'h00F0, 16'h00F0, 16'h8000, 16'h5555};
        s_sh   = '{4'd4, 4'd12, 4'd1, 4'd1};
        s_exp  = '{16'h0F00, 16'h000F, 16'h0001, 16'hAAAA};
        for (int i = 0; i < 4; i++) begin
            ifc.in_valid = 1'b1;
            ifc.in_data  = s_data[i];
            ifc.in_shift = s_sh[i];
            ifc.in_tag   = 4'(i + 9);
            tick();
        end
        ifc.in_valid = 1'b0;
        guard = 0;
        while (!ifc.out_valid && guard < 20) begin
            tick();
            guard++;
        end
        chk("bp_reached_out", 32'(ifc.out_valid), 32'd1);
        ifc.out_ready = 1'b0;
        #1;
        hold_d = ifc.out_data;
        hold_t = ifc.out_tag;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_in_ready", 32'(ifc.in_ready), 32'd0);
            chk("bp_out_valid", 32'(ifc.out_valid), 32'd1);
            chk("bp_data_stable", 32'(ifc.out_data), 32'(hold_d));
            chk("bp_tag_stable", 32'(ifc.out_tag), 32'(hold_t));
            tick();
        end
        ifc.out_ready = 1'b1;
        drain(4);
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            chk("bp_data", 32'(got_q[i][19:4]), 32'(s_exp[i]));
            chk("bp_tag", 32'(got_q[i][3:0]), 32'(i + 9));
        end

        // Shift sweep on a single set bit.
        got_q.delete();
        for (int s = 0; s < 16; s++) begin
            ifc.in_valid = 1'b1;
            ifc.in_data  = 16'h0001;
            ifc.in_shift = 4'(s);
            ifc.in_tag   = 4'(s);
            tick();
        end
        ifc.in_valid = 1'b0;
        drain(16);
        for (int s = 0; s < 16 && s < got_q.size(); s++) begin
            chk("sweep_data", 32'(got_q[s][19:4]), 32'(1 << s));
        end

        // Random traffic with random backpressure; tick() scoreboards every result.
        acc0  = n_acc;
        guard = 0;
        while ((n_acc - acc0) < 10000 && guard < 60000) begin
            ifc.in_valid  = ($urandom_range(0, 9) < 7);
            ifc.in_data   = 16'($urandom);
            ifc.in_shift  = 4'($urandom);
            ifc.in_tag    = 4'($urandom);
            ifc.out_ready = ($urandom_range(0, 3) != 0);
            tick();
            guard++;
        end
        ifc.in_valid  = 1'b0;
        ifc.out_ready = 1'b1;
        repeat (10) tick();
        chk("rand_accepted", 32'(n_acc - acc0), 32'd10000);
        chk("rand_drained", 32'(exp_q.size()), 32'd0);

        // Reset with operands in flight.
        got_q.delete();
        send(16'h1111, 4'd1, 4'd1);
        send(16'h2222, 4'd2, 4'd2);
        send(16'h3333, 4'd3, 4'd3);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(ifc.out_valid), 32'd0);
        chk("midrst_out_data", 32'(ifc.out_data), 32'd0);
        chk("midrst_out_tag", 32'(ifc.out_tag), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        nv = 0;
        for (int i = 0; i < 8; i++) begin
            nv += 32'(ifc.out_valid);
            tick();
        end
        chk("midrst_no_stale", 32'(nv), 32'd0);
        send(16'h1234, 4'd4, 4'd7);
        drain(1);
        if (got_q.size() > 0) begin
            chk("post_rst_data", 32'(got_q[0][19:4]), 32'h2341);
            chk("post_rst_tag", 32'(got_q[0][3:0]), 32'd7);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
